// File: rtl/dm_pkg.sv
// Shared size encodings and alignment helpers for the sized data memory.
package dm_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   // Half needs an even address, word needs a multiple of four.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic mis;
      mis = 1'b0;
      case (size)
         SZ_HALF: mis = addr_lo[0];
         SZ_WORD: mis = |addr_lo;
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

   // Number of bytes touched by an access; 0 for the illegal encoding.
   function automatic int unsigned size_bytes(input logic [1:0] size);
      int unsigned n;
      case (size)
         SZ_BYTE: n = 1;
         SZ_HALF: n = 2;
         SZ_WORD: n = 4;
         default: n = 0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/dmem_sized_sync_if.sv
// Request/response bundle between the datapath and the sized data memory.
interface dmem_sized_sync_if;

   logic        dm_cs;
   logic        dm_wr;
   logic        dm_rd;
   logic [1:0]  size;
   logic        sign_ext;
   logic [31:0] Address;
   logic [31:0] D_in;
   logic [31:0] D_Out;
   logic        rd_valid;
   logic        acc_err;
   logic        err_stky;

   modport master (
      output dm_cs, dm_wr, dm_rd, size, sign_ext, Address, D_in,
      input  D_Out, rd_valid, acc_err, err_stky
   );

   modport slave (
      input  dm_cs, dm_wr, dm_rd, size, sign_ext, Address, D_in,
      output D_Out, rd_valid, acc_err, err_stky
   );

endinterface

// File: rtl/dm_lane_align.sv
// Byte-lane steering: store enables/data per bank and load extraction/extension.
module dm_lane_align
   import dm_pkg::*;
#(
   parameter bit BIG_END = 1'b1
) (
   input  logic [1:0]       size,
   input  logic [1:0]       addr_lo,
   input  logic             sign_ext,
   input  logic [31:0]      d_in,
   input  logic [3:0][7:0]  rd_lanes,
   output logic [3:0]       wr_en,
   output logic [3:0][7:0]  wr_lanes,
   output logic [31:0]      ld_data
);

   int unsigned n;
   int unsigned o;

   assign n = size_bytes(size);
   assign o = {30'd0, addr_lo};

   // Store: bank k takes access byte j = k - o; byte j is the most significant one when big-endian.
   always_comb begin
      wr_en    = '0;
      wr_lanes = '0;
      for (int unsigned k = 0; k < 4; k++) begin
         if (k >= o && k < o + n) begin
            wr_en[k]    = 1'b1;
            wr_lanes[k] = BIG_END ? d_in[8*(n-1-(k-o)) +: 8] : d_in[8*(k-o) +: 8];
         end
      end
   end

   // Load: gather the touched banks right-justified, then extend byte/half.
   always_comb begin
      logic [31:0] raw;
      raw = '0;
      for (int unsigned j = 0; j < 4; j++) begin
         if (j < n && o + j < 4) begin
            if (BIG_END) raw[8*(n-1-j) +: 8] = rd_lanes[o+j];
            else         raw[8*j +: 8]       = rd_lanes[o+j];
         end
      end
      ld_data = raw;
      if (size == SZ_BYTE) ld_data = {{24{sign_ext & raw[7]}}, raw[7:0]};
      else if (size == SZ_HALF) ld_data = {{16{sign_ext & raw[15]}}, raw[15:0]};
   end

endmodule

// File: rtl/dmem_sized_sync.sv
// Byte-addressable sized data memory with registered read, access checking and error flags.
module dmem_sized_sync
   import dm_pkg::*;
#(
   parameter int unsigned ADDR_W  = 12,
   parameter int unsigned DATA_W  = 32,
   parameter bit          BIG_END = 1'b1
) (
   input logic             clk,
   input logic             reset,
   dmem_sized_sync_if.slave bus
);

   localparam int unsigned Lanes = DATA_W / 8;
   localparam int unsigned Words = 1 << (ADDR_W - 2);

   logic [7:0]        mem [Lanes][Words];
   logic [ADDR_W-3:0] widx;
   logic [3:0][7:0]   rd_lanes;
   logic [3:0][7:0]   wr_lanes;
   logic [3:0]        wr_en;
   logic [31:0]       ld_data;
   logic              req, bad, do_wr, do_rd, rej;
   logic [31:0]       d_out_q;
   logic              rd_valid_q, acc_err_q, err_stky_q;

   assign widx = bus.Address[ADDR_W-1:2];

   // Accept/reject decode; a request with both strobes set is rejected outright.
   always_comb begin
      req   = bus.dm_cs & (bus.dm_wr | bus.dm_rd);
      bad   = (bus.dm_wr & bus.dm_rd) | (bus.size == SZ_ILL)
            | is_misaligned(bus.size, bus.Address[1:0]) | (|bus.Address[31:ADDR_W]);
      do_wr = req & ~bad & bus.dm_wr;
      do_rd = req & ~bad & bus.dm_rd;
      rej   = req & bad;
   end

   dm_lane_align #(
      .BIG_END (BIG_END)
   ) u_align (
      .size     (bus.size),
      .addr_lo  (bus.Address[1:0]),
      .sign_ext (bus.sign_ext),
      .d_in     (bus.D_in),
      .rd_lanes (rd_lanes),
      .wr_en    (wr_en),
      .wr_lanes (wr_lanes),
      .ld_data  (ld_data)
   );

   // Present the addressed word of every bank to the load aligner.
   always_comb begin
      rd_lanes = '0;
      for (int unsigned k = 0; k < 4; k++) rd_lanes[k] = mem[k][widx];
   end

   // Byte-bank writes; not reset, and suppressed on a reset edge.
   always_ff @(posedge clk) begin
      if (!reset && do_wr) begin
         for (int unsigned k = 0; k < 4; k++) begin
            if (wr_en[k]) mem[k][widx] <= wr_lanes[k];
         end
      end
   end

   // Output registers: D_Out holds between loads, strobes pulse for one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         d_out_q    <= '0;
         rd_valid_q <= 1'b0;
         acc_err_q  <= 1'b0;
         err_stky_q <= 1'b0;
      end else begin
         rd_valid_q <= do_rd;
         acc_err_q  <= rej;
         err_stky_q <= err_stky_q | rej;
         if (do_rd) d_out_q <= ld_data;
      end
   end

   assign bus.D_Out    = d_out_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.acc_err  = acc_err_q;
   assign bus.err_stky = err_stky_q;

endmodule

// File: tb/tb_dmem_sized_sync.sv
// Randomised and directed bench for dmem_sized_sync against a byte-array model.
module tb_dmem_sized_sync;

   logic clk;
   logic reset;
   dmem_sized_sync_if bus ();

   dmem_sized_sync #(
      .ADDR_W  (12),
      .DATA_W  (32),
      .BIG_END (1'b1)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0]  ref_mem [4096];
   logic [31:0] exp_dout;
   bit          exp_valid, exp_err, exp_stky;
   int          n_checks, n_fail;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One clock of stimulus; the model applies the access rules byte by byte, big-endian.
   task automatic op(input bit rst_in, input bit cs, input bit wr, input bit rd,
                     input logic [1:0] sz, input bit sx, input logic [31:0] a,
                     input logic [31:0] d);
      int unsigned n;
      bit          req, legal;
      logic [31:0] v;
      @(negedge clk);
      reset        = rst_in;
      bus.dm_cs    = cs;
      bus.dm_wr    = wr;
      bus.dm_rd    = rd;
      bus.size     = sz;
      bus.sign_ext = sx;
      bus.Address  = a;
      bus.D_in     = d;
      n     = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
      req   = cs && (wr || rd);
      legal = cs && (wr != rd) && n != 0 && (a % n) == 0 && a < 32'd4096;
      if (rst_in) begin
         exp_dout = '0; exp_valid = 0; exp_err = 0; exp_stky = 0;
      end else begin
         exp_valid = legal && rd;
         exp_err   = req && !legal;
         exp_stky  = exp_stky | exp_err;
         if (legal && wr)
            for (int unsigned i = 0; i < n; i++) ref_mem[a+i] = 8'(d >> (8*(n-1-i)));
         if (legal && rd) begin
            v = '0;
            for (int unsigned i = 0; i < n; i++) v = (v << 8) | 32'(ref_mem[a+i]);
            if (n == 1 && sx && v[7])  v = v | 32'hFFFF_FF00;
            if (n == 2 && sx && v[15]) v = v | 32'hFFFF_0000;
            exp_dout = v;
         end
      end
      @(posedge clk);
      #1;
      check_eq("rd_valid", {31'd0, bus.rd_valid}, {31'd0, exp_valid});
      check_eq("acc_err",  {31'd0, bus.acc_err},  {31'd0, exp_err});
      check_eq("err_stky", {31'd0, bus.err_stky}, {31'd0, exp_stky});
      check_eq("D_Out",    bus.D_Out, exp_dout);
   endtask

   task automatic sw(input logic [31:0] a, input logic [31:0] d);
      op(0, 1, 1, 0, 2'd2, 0, a, d);
   endtask
   task automatic ld(input logic [1:0] sz, input bit sx, input logic [31:0] a);
      op(0, 1, 0, 1, sz, sx, a, 32'h0);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      exp_dout = '0; exp_valid = 0; exp_err = 0; exp_stky = 0;
      reset = 1'b1;
      bus.dm_cs = 0; bus.dm_wr = 0; bus.dm_rd = 0; bus.size = 0;
      bus.sign_ext = 0; bus.Address = 0; bus.D_in = 0;

      // Reset, idle, then fill the working region with zeros.
      op(1, 0, 0, 0, 2'd0, 0, 32'h0, 32'h0);
      op(1, 1, 0, 1, 2'd2, 0, 32'h0, 32'h0);
      op(0, 0, 0, 0, 2'd0, 0, 32'h0, 32'h0);
      for (int unsigned w = 0; w < 64; w++) sw(w * 4, 32'h0);
      ld(2'd2, 0, 32'h0);
      op(0, 0, 0, 0, 2'd0, 0, 32'h0, 32'h0);

      // Word store, then byte/half views of it.
      sw(32'h10, 32'h1122_3344);
      ld(2'd2, 0, 32'h10);
      ld(2'd0, 0, 32'h10);
      ld(2'd0, 0, 32'h13);
      ld(2'd1, 0, 32'h12);

      // Byte store into a word, signed and unsigned reads.
      op(0, 1, 1, 0, 2'd0, 0, 32'h21, 32'h0000_0080);
      ld(2'd2, 0, 32'h20);
      ld(2'd0, 1, 32'h21);
      ld(2'd0, 0, 32'h21);
      ld(2'd1, 1, 32'h20);

      // Rejected stores leave the array untouched.
      sw(32'h20, 32'hCAFE_F00D);
      sw(32'h22, 32'h1111_1111);
      op(0, 1, 1, 0, 2'd1, 0, 32'h31, 32'h2222);
      op(0, 1, 1, 0, 2'd3, 0, 32'h20, 32'h3333_3333);
      ld(2'd2, 0, 32'h20);
      ld(2'd1, 1, 32'h30);

      // Out of range load and double-strobe request.
      ld(2'd2, 0, 32'h0000_1000);
      op(0, 1, 1, 1, 2'd2, 0, 32'h20, 32'h4444_4444);
      ld(2'd2, 0, 32'h20);

      // Back-to-back store/load, and a store suppressed by reset.
      sw(32'h40, 32'hDEAD_BEEF);
      ld(2'd2, 0, 32'h40);
      op(1, 1, 1, 0, 2'd2, 0, 32'h40, 32'h5555_5555);
      ld(2'd2, 0, 32'h40);

      // Random traffic over the zero-filled region with occasional bad accesses.
      for (int i = 0; i < 400; i++) begin
         logic [31:0] a;
         logic [1:0]  sz;
         bit          cs, wr, rd;
         cs = ($urandom_range(0, 9) != 0);
         case ($urandom_range(0, 9))
            0:       begin wr = 1; rd = 1; end
            1:       begin wr = 0; rd = 0; end
            2, 3, 4: begin wr = 1; rd = 0; end
            default: begin wr = 0; rd = 1; end
         endcase
         sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         a  = 32'($urandom_range(0, 255));
         if ($urandom_range(0, 3) != 0) begin
            if (sz == 2'd1) a[0] = 1'b0;
            if (sz == 2'd2) a[1:0] = 2'b00;
         end
         if ($urandom_range(0, 19) == 0) a = a | (32'h1000 << $urandom_range(0, 19));
         op(0, cs, wr, rd, sz, 1'($urandom_range(0, 1)), a, $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
